// File: rtl/entry_controller_pkg.sv
// Shared definitions for the door-lock entry controller: state encodings,
// default cycle constants and the zero-to-one cycle helper.
package entry_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2,
    ST_MASTER  = 2'd3
  } state_e;

  localparam int unsigned DEF_MAX_FAILS      = 3;
  localparam int unsigned DEF_FAIL_W         = 2;
  localparam int unsigned DEF_OPEN_CYCLES    = 50000000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 500000000;
  localparam int unsigned DEF_MASTER_TIMEOUT = 500000000;
  localparam int unsigned DEF_TMR_W          = 32;

  // A zero-length hold would never expire, so it is stretched to one cycle.
  function automatic int unsigned at_least_one(input int unsigned cycles);
    return (cycles == 0) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/entry_controller_cycle_timer.sv
// Loadable down counter shared by all timed states; expire flags the final
// cycle of the loaded interval (count == 1).
module cycle_timer #(
  parameter int unsigned TMR_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TMR_W'(1);
    end
  end

  assign expire = (count == TMR_W'(1));

endmodule

// File: rtl/entry_controller.sv
// Decision stage after the password comparators: door-open hold, wrong-entry
// counting with timed lockout, and master-mode password programming.
module entry_controller
  import entry_controller_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned FAIL_W         = DEF_FAIL_W,
  parameter int unsigned OPEN_CYCLES    = DEF_OPEN_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned MASTER_TIMEOUT = DEF_MASTER_TIMEOUT,
  parameter int unsigned TMR_W          = DEF_TMR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              confirm,
  input  logic              same,
  input  logic              master_same,
  input  logic              cancel,
  output logic              unlock,
  output logic              wrong,
  output logic              locked_out,
  output logic              master_mode,
  output logic              pw_write,
  output logic              clear_input,
  output logic [FAIL_W-1:0] fail_count
);

  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  OPEN_LOAD    = TMR_W'(at_least_one(OPEN_CYCLES));
  localparam logic [TMR_W-1:0]  LOCKOUT_LOAD = TMR_W'(at_least_one(LOCKOUT_CYCLES));
  localparam logic [TMR_W-1:0]  MASTER_LOAD  = TMR_W'(at_least_one(MASTER_TIMEOUT));

  state_e            state, state_d;
  logic [FAIL_W-1:0] fail_d, fail_inc;
  logic              wrong_d, pw_write_d, clear_d;
  logic              load, expire;
  logic [TMR_W-1:0]  load_val;

  cycle_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  always_comb begin
    state_d    = state;
    fail_d     = fail_count;
    wrong_d    = 1'b0;
    pw_write_d = 1'b0;
    clear_d    = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    fail_inc   = (fail_count == FAIL_LIMIT) ? fail_count : fail_count + FAIL_W'(1);

    case (state)
      ST_IDLE: begin
        if (confirm) begin
          clear_d = 1'b1;
          if (master_same) begin
            state_d  = ST_MASTER;
            fail_d   = '0;
            load     = 1'b1;
            load_val = MASTER_LOAD;
          end else if (same) begin
            state_d  = ST_OPEN;
            fail_d   = '0;
            load     = 1'b1;
            load_val = OPEN_LOAD;
          end else begin
            wrong_d = 1'b1;
            fail_d  = fail_inc;
            if (fail_inc == FAIL_LIMIT) begin
              state_d  = ST_LOCKOUT;
              load     = 1'b1;
              load_val = LOCKOUT_LOAD;
            end
          end
        end else if (cancel) begin
          clear_d = 1'b1;
        end
      end
      ST_OPEN: begin
        if (expire) state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (expire) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      ST_MASTER: begin
        // Timer expiry outranks a coincident confirm.
        if (expire) begin
          state_d = ST_IDLE;
        end else if (confirm) begin
          state_d    = ST_IDLE;
          pw_write_d = 1'b1;
          clear_d    = 1'b1;
        end else if (cancel) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      unlock      <= 1'b0;
      wrong       <= 1'b0;
      locked_out  <= 1'b0;
      master_mode <= 1'b0;
      pw_write    <= 1'b0;
      clear_input <= 1'b0;
      fail_count  <= '0;
    end else begin
      state       <= state_d;
      unlock      <= (state_d == ST_OPEN);
      wrong       <= wrong_d;
      locked_out  <= (state_d == ST_LOCKOUT);
      master_mode <= (state_d == ST_MASTER);
      pw_write    <= pw_write_d;
      clear_input <= clear_d;
      fail_count  <= fail_d;
    end
  end

endmodule
